fpu_issue_sequencer: RTL

- Multi-cycle controller that owns the 32-entry single-precision FP register file and sequences the combinational FP add/sub datapath (coprocessor1).
- Accepts one FP instruction at a time from the integer pipeline through a valid/ready handshake.
- Presents latched operands and the ALU command to the datapath, then holds them for a programmable number of settle cycles.
- Writes the datapath result back to the register file and reports completion, so the datapath is treated as a multicycle path.

---
 rtl/fpu_issue_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_issue_sequencer
//   Owns the 32 x 32-bit single-precision FP register file and sequences an
//   external combinational add/sub datapath as a multicycle path. It accepts
//   one instruction at a time, latches the operands onto dp_*, holds them for
//   EXEC_CYCLES cycles, then writes the result back and pulses resp_valid.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   req_valid / req_ready     request handshake (ready only in IDLE)
//   req_op/fs/ft/fd/wdata     instruction fields, sampled on the accept edge
//   dp_data1/2, dp_aluop      registered operands / command to the datapath
//   dp_result                 combinational datapath result
//   resp_valid/data/fd/err    one-cycle completion report
//   busy                      sequencer is not idle
// ---------------------------------------------------------------------------
module fpu_issue_sequencer #(
   parameter int         EXEC_CYCLES = 2,
   parameter logic [2:0] ALU_ADD     = 3'd0,
   parameter logic [2:0] ALU_SUB     = 3'd1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [4:0]  req_fs,
   input  logic [4:0]  req_ft,
   input  logic [4:0]  req_fd,
   input  logic [31:0] req_wdata,
   output logic [31:0] dp_data1,
   output logic [31:0] dp_data2,
   output logic [2:0]  dp_aluop,
   input  logic [31:0] dp_result,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_fd,
   output logic        resp_err,
   output logic        busy
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_MTC1 = 3'b011;
   localparam logic [2:0] OP_MFC1 = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [4:0]  r_fs;
   logic [4:0]  r_ft;
   logic [4:0]  r_fd;
   logic [3:0]  r_cnt;
   logic        r_wen;       // WB commits resp_data into r_rf[r_fd]
   logic [31:0] r_rf [32];
   logic [31:0] r_dp_data1;
   logic [31:0] r_dp_data2;
   logic [2:0]  r_dp_aluop;
   logic        r_resp_valid;
   logic [31:0] r_resp_data;
   logic [4:0]  r_resp_fd;
   logic        r_resp_err;

   wire w_accept = req_valid && req_ready;

   assign req_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign dp_data1   = r_dp_data1;
   assign dp_data2   = r_dp_data2;
   assign dp_aluop   = r_dp_aluop;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_fd    = r_resp_fd;
   assign resp_err   = r_resp_err;

   // The response registers double as the result latch: they are loaded on
   // every transition into WB so resp_valid is high during the WB cycle and
   // the writeback at the end of WB uses the same value that was reported.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_op         <= OP_ADD;
         r_fs         <= '0;
         r_ft         <= '0;
         r_fd         <= '0;
         r_cnt        <= '0;
         r_wen        <= 1'b0;
         r_dp_data1   <= '0;
         r_dp_data2   <= '0;
         r_dp_aluop   <= ALU_ADD;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_fd    <= '0;
         r_resp_err   <= 1'b0;
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op <= req_op;
                  r_fs <= req_fs;
                  r_ft <= req_ft;
                  r_fd <= req_fd;
                  if (req_op == OP_MTC1) begin
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= req_wdata;
                     r_resp_fd    <= req_fd;
                     r_resp_err   <= 1'b0;
                     r_wen        <= 1'b1;
                     r_state      <= S_WB;
                  end else if (req_op > OP_MFC1) begin
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= '0;
                     r_resp_fd    <= '0;
                     r_resp_err   <= 1'b1;
                     r_wen        <= 1'b0;
                     r_state      <= S_WB;
                  end else begin
                     r_state <= S_READ;
                  end
               end
            end

            S_READ: begin
               r_dp_data1 <= r_rf[r_fs];
               r_dp_data2 <= r_rf[r_ft];
               r_dp_aluop <= (r_op == OP_SUB) ? ALU_SUB : ALU_ADD;
               if (r_op == OP_ADD || r_op == OP_SUB) begin
                  r_cnt   <= 4'(EXEC_CYCLES - 1);
                  r_state <= S_EXEC;
               end else begin
                  // mov.s writes fd; mfc1 only reports fs
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= r_rf[r_fs];
                  r_resp_fd    <= (r_op == OP_MOV) ? r_fd : 5'd0;
                  r_resp_err   <= 1'b0;
                  r_wen        <= (r_op == OP_MOV);
                  r_state      <= S_WB;
               end
            end

            S_EXEC: begin
               // dp_* stay frozen here; dp_result is trusted only once the
               // counter has run out.
               if (r_cnt == 4'd0) begin
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= dp_result;
                  r_resp_fd    <= r_fd;
                  r_resp_err   <= 1'b0;
                  r_wen        <= 1'b1;
                  r_state      <= S_WB;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            S_WB: begin
               if (r_wen) r_rf[r_fd] <= r_resp_data;
               r_wen        <= 1'b0;
               r_resp_valid <= 1'b0;
               r_state      <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
